rtc_access_arbiter: RTL
=======================

RTC_ACCESS_ARBITER -- requirements
Module: rtc_access_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd200: max cycles waited for bus_done before abort.
REQ-002 CLK  input  1  system clock, all state on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 req_init/req_wr/req_rd  input  1 each  transaction requests (init sequencer, user write-back, periodic read sweep).
REQ-005 addr_init/addr_wr/addr_rd  input  7 each  RTC register address per requester.
REQ-006 data_init/data_wr  input  8 each  write data; init and wr are writes, rd is a read.
REQ-007 gnt_init/gnt_wr/gnt_rd  output  1 each  owner indication, one-hot or all zero.
REQ-008 done_init/done_wr/done_rd  output  1 each  one-cycle completion pulse to owner.
REQ-009 err  output  1  one-cycle pulse coincident with done when the transaction was rejected or timed out.
REQ-010 rd_data  output  8  last read value, held until next successful read.
REQ-011 bus_start  output  1  one-cycle pulse launching a bus transaction.
REQ-012 bus_we, bus_addr[6:0], bus_wdata[7:0]  output  bus command, stable from bus_start until done.
REQ-013 bus_rdata  input  8  read data, valid with bus_done.
REQ-014 bus_done  input  1  bus controller completion pulse (read/write finished).

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RELEASE; exactly one active.
REQ-016 IDLE: priority init > wr/rd; with no request, stay IDLE.
REQ-017 wr vs rd when both pending: grant the one not granted last (alternation); a single pending one is granted directly.
REQ-018 Winner selected in IDLE at edge N; gnt_x, latched bus_addr/bus_wdata/bus_we asserted from N+1 (ISSUE).
REQ-019 Latched address/data not re-sampled until next grant; requester changes after grant ignored.
REQ-020 Legal addresses: 0x00-0x02, 0x10, 0x21-0x27, 0x41-0x43; illegal address: ISSUE goes to RELEASE without bus_start, done_x+err pulse.
REQ-021 Legal address: bus_start pulses one cycle in ISSUE, then WAIT.
REQ-022 WAIT: 8-bit counter from 0, +1 per cycle; bus_done exits to RELEASE; bus_done outside WAIT ignored.
REQ-023 Counter reaching TIMEOUT without bus_done: RELEASE with err pulse; rd_data unchanged.
REQ-024 Successful read: rd_data <= bus_rdata on bus_done edge.
REQ-025 RELEASE lasts one cycle: done_x pulses, gnt_x deasserts at end, return to IDLE; next grant earliest two cycles after bus_done.
REQ-026 bus_done in the same cycle as timeout expiry counts as success.
REQ-027 Requester dropping req mid-transaction does not abort; done still pulses.
REQ-028 Requester holding req after done is re-arbitrated normally (alternation still applies).

Reset
REQ-029 RST asserted anytime: state IDLE, all gnt/done/err/bus_start/bus_we = 0, bus_addr = 0, bus_wdata = 0, rd_data = 0, counter = 0, last-granted = rd (so wr wins first tie).
REQ-030 Reset mid-transaction abandons it silently; no done pulse after release.

Structure
REQ-031 Shared package holds state encoding, legal-address constants (0x02, 0x10, 0x21, 0x27, 0x41, 0x43), default TIMEOUT.
REQ-032 One sub-module rtc_addr_check (combinational legality decode) instantiated once on the selected address.

Verification
REQ-033 req_rd, addr 0x21, bus_done 5 cycles after bus_start with rdata 0x59 -> one bus_start, bus_we=0, done_rd + rd_data=0x59, err=0.
REQ-034 req_wr and req_rd held simultaneously from reset -> grant order wr, rd, wr, rd; never two gnt high.
REQ-035 req_init raised while rd in WAIT -> rd completes first, init granted next regardless of pending wr.
REQ-036 req_wr addr 0x30 -> no bus_start, done_wr and err pulse two cycles after grant.
REQ-037 bus_done never returned, TIMEOUT=200 -> err+done after 200 WAIT cycles, rd_data unchanged; bus_done at exactly cycle 200 -> success.
REQ-038 RST pulsed during WAIT -> all outputs zero immediately, no done pulse, next request handled normally.

Source files
------------

// File: rtl/rtc_access_arbiter_pkg.sv
// Shared definitions for the RTC register-access arbiter.
// Holds the FSM state encoding, the owner encoding, the legal RTC register
// address map boundaries and the default bus timeout.
package rtc_access_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnInit = 2'd1,
    OwnWr   = 2'd2,
    OwnRd   = 2'd3
  } owner_e;

  // Legal register windows: 0x00..0x02, 0x10, 0x21..0x27, 0x41..0x43.
  localparam logic [6:0] AddrCtrlLast   = 7'h02;
  localparam logic [6:0] AddrStatus     = 7'h10;
  localparam logic [6:0] AddrTimeFirst  = 7'h21;
  localparam logic [6:0] AddrTimeLast   = 7'h27;
  localparam logic [6:0] AddrAlarmFirst = 7'h41;
  localparam logic [6:0] AddrAlarmLast  = 7'h43;

  localparam logic [7:0] TimeoutDefault = 8'd200;

endpackage

// File: rtl/rtc_addr_check.sv
// Combinational RTC address legality decode.
// Ports:
//   addr_i  - 7-bit register address of the currently selected requester
//   legal_o - high when addr_i falls inside one of the implemented windows
module rtc_addr_check
  import rtc_access_arbiter_pkg::*;
(
  input  logic [6:0] addr_i,
  output logic       legal_o
);

  assign legal_o = (addr_i <= AddrCtrlLast) ||
                   (addr_i == AddrStatus) ||
                   ((addr_i >= AddrTimeFirst) && (addr_i <= AddrTimeLast)) ||
                   ((addr_i >= AddrAlarmFirst) && (addr_i <= AddrAlarmLast));

endmodule

// File: rtl/rtc_access_arbiter.sv
// Arbitrates three requesters (init sequencer, user write-back, periodic read
// sweep) onto a single RTC register bus. Init has absolute priority; wr and rd
// alternate when both are pending. The winner's command is latched at grant,
// illegal addresses are rejected without touching the bus, and a stuck bus is
// aborted after TIMEOUT wait cycles.
// Ports:
//   CLK, RST                      - clock, asynchronous active-high reset
//   req_*/addr_*/data_*           - per-requester request, address, write data
//   gnt_*/done_*                  - owner indication and completion pulse
//   err                           - rejected/timed-out flag, coincident with done
//   rd_data                       - last successfully read value
//   bus_start/bus_we/bus_addr/bus_wdata - command to the bus controller
//   bus_rdata/bus_done            - response from the bus controller
module rtc_access_arbiter
  import rtc_access_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TimeoutDefault
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_init,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [6:0] addr_init,
  input  logic [6:0] addr_wr,
  input  logic [6:0] addr_rd,
  input  logic [7:0] data_init,
  input  logic [7:0] data_wr,
  output logic       gnt_init,
  output logic       gnt_wr,
  output logic       gnt_rd,
  output logic       done_init,
  output logic       done_wr,
  output logic       done_rd,
  output logic       err,
  output logic [7:0] rd_data,
  output logic       bus_start,
  output logic       bus_we,
  output logic [6:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_done
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d, sel_owner;
  logic       last_wr_q, last_wr_d;
  logic [6:0] addr_q, addr_d, sel_addr;
  logic [7:0] wdata_q, wdata_d, sel_wdata;
  logic       we_q, we_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       sel_legal;
  logic       timeout_hit;

  // Requester selection; last_wr_q breaks wr/rd ties in favour of the other one.
  always_comb begin
    sel_owner = OwnNone;
    sel_addr  = addr_rd;
    sel_wdata = '0;
    if (req_init) begin
      sel_owner = OwnInit;
      sel_addr  = addr_init;
      sel_wdata = data_init;
    end else if (req_wr && (!req_rd || !last_wr_q)) begin
      sel_owner = OwnWr;
      sel_addr  = addr_wr;
      sel_wdata = data_wr;
    end else if (req_rd) begin
      sel_owner = OwnRd;
      sel_addr  = addr_rd;
    end
  end

  rtc_addr_check u_addr_check (
    .addr_i  (sel_addr),
    .legal_o (sel_legal)
  );

  // True in the TIMEOUT-th wait cycle; bus_done in that same cycle still wins.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_owner != OwnNone) begin
          state_d = StIssue;
          owner_d = sel_owner;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = (sel_owner != OwnRd);
          start_d = sel_legal;
          if (sel_owner == OwnWr) begin
            last_wr_d = 1'b1;
          end else if (sel_owner == OwnRd) begin
            last_wr_d = 1'b0;
          end
        end
      end
      StIssue: begin
        cnt_d = '0;
        // start_q is only set for a legal address, so it doubles as the legality flag.
        if (start_q) begin
          state_d = StWait;
        end else begin
          state_d = StRelease;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      StWait: begin
        if (bus_done) begin
          state_d = StRelease;
          done_d  = 1'b1;
          if (!we_q) begin
            rd_data_d = bus_rdata;
          end
        end else if (timeout_hit) begin
          state_d = StRelease;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRelease: begin
        state_d = StIdle;
        owner_d = OwnNone;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      owner_q   <= OwnNone;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      start_q   <= start_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign gnt_init  = (owner_q == OwnInit);
  assign gnt_wr    = (owner_q == OwnWr);
  assign gnt_rd    = (owner_q == OwnRd);
  assign done_init = done_q && (owner_q == OwnInit);
  assign done_wr   = done_q && (owner_q == OwnWr);
  assign done_rd   = done_q && (owner_q == OwnRd);
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign bus_start = start_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule
